// File: rtl/march_pkg.sv
// Shared constants and state encoding for the ray_cube marcher scheduler.
package march_pkg;

    localparam int unsigned W            = 16;
    localparam int unsigned VEC_W        = 3 * W;
    localparam int unsigned MARCH_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/march_scheduler_rr_arbiter.sv
// Combinational round-robin grant: first requester above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    logic [PW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((32'(ptr) + k) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/march_scheduler.sv
// Time-shares one fixed-latency marcher between NUM_REQ requesters.
module march_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned W            = march_pkg::W,
    parameter int unsigned MARCH_CYCLES = march_pkg::MARCH_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     abort,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3*W-1:0]   req_origin,
    input  logic [NUM_REQ*3*W-1:0]   req_dir,
    input  logic [NUM_REQ*3*W-1:0]   req_light,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_hit,
    output logic [W-1:0]             rsp_intensity,
    output logic                     m_start,
    output logic [3*W-1:0]           m_origin,
    output logic [3*W-1:0]           m_dir,
    output logic [3*W-1:0]           m_light,
    input  logic                     m_hit,
    input  logic [W-1:0]             m_intensity,
    output logic                     busy
);

    import march_pkg::*;

    localparam int unsigned VW = 3 * W;
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MARCH_CYCLES);

    state_t               state, state_d;
    logic [PW-1:0]        ptr, ptr_d, tag, tag_d, gidx;
    logic [CW-1:0]        count, count_d;
    logic [VW-1:0]        origin_d, dir_d, light_d;
    logic [NUM_REQ-1:0]   rsp_valid_d, grant;
    logic                 rsp_hit_d, grant_valid;
    logic [W-1:0]         rsp_intensity_d;
    logic [VW-1:0]        origin_arr [NUM_REQ];
    logic [VW-1:0]        dir_arr    [NUM_REQ];
    logic [VW-1:0]        light_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign origin_arr[g] = req_origin[g*VW +: VW];
        assign dir_arr[g]    = req_dir[g*VW +: VW];
        assign light_arr[g]  = req_light[g*VW +: VW];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // One-hot grant to requester index
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[PW'(i)]) gidx = PW'(i);
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_d         = state;
        ptr_d           = ptr;
        tag_d           = tag;
        count_d         = count;
        origin_d        = m_origin;
        dir_d           = m_dir;
        light_d         = m_light;
        rsp_valid_d     = '0;
        rsp_hit_d       = rsp_hit;
        rsp_intensity_d = rsp_intensity;
        req_ready       = '0;
        m_start         = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && grant_valid) begin
                    req_ready = grant;
                    origin_d  = origin_arr[gidx];
                    dir_d     = dir_arr[gidx];
                    light_d   = light_arr[gidx];
                    tag_d     = gidx;
                    ptr_d     = gidx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    m_start = 1'b1;
                    count_d = CW'(MARCH_CYCLES - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Abort beats the final count: job dropped, result not captured
                if (abort) begin
                    state_d = IDLE;
                end else if (count == '0) begin
                    rsp_hit_d        = m_hit;
                    rsp_intensity_d  = m_intensity;
                    rsp_valid_d[tag] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    count_d = count - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            tag           <= '0;
            count         <= '0;
            m_origin      <= '0;
            m_dir         <= '0;
            m_light       <= '0;
            rsp_valid     <= '0;
            rsp_hit       <= 1'b0;
            rsp_intensity <= '0;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            tag           <= tag_d;
            count         <= count_d;
            m_origin      <= origin_d;
            m_dir         <= dir_d;
            m_light       <= light_d;
            rsp_valid     <= rsp_valid_d;
            rsp_hit       <= rsp_hit_d;
            rsp_intensity <= rsp_intensity_d;
        end
    end

endmodule

// File: tb/tb_march_scheduler.sv
// Self-checking bench for march_scheduler against a job-level timing model.
module tb_march_scheduler;

    localparam int unsigned N  = 2;
    localparam int unsigned WD = 16;
    localparam int unsigned M  = 8;
    localparam int unsigned VW = 3 * WD;
    localparam int unsigned PW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              abort;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*VW-1:0]   req_origin, req_dir, req_light;
    logic [N-1:0]      rsp_valid;
    logic              rsp_hit;
    logic [WD-1:0]     rsp_intensity;
    logic              m_start;
    logic [VW-1:0]     m_origin, m_dir, m_light;
    logic              m_hit;
    logic [WD-1:0]     m_intensity;
    logic              busy;

    logic [VW-1:0]     o_in [N];
    logic [VW-1:0]     d_in [N];
    logic [VW-1:0]     l_in [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_origin[g*VW +: VW] = o_in[g];
        assign req_dir[g*VW +: VW]    = d_in[g];
        assign req_light[g*VW +: VW]  = l_in[g];
    end

    march_scheduler #(.NUM_REQ(N), .W(WD), .MARCH_CYCLES(M)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort         (abort),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_origin    (req_origin),
        .req_dir       (req_dir),
        .req_light     (req_light),
        .rsp_valid     (rsp_valid),
        .rsp_hit       (rsp_hit),
        .rsp_intensity (rsp_intensity),
        .m_start       (m_start),
        .m_origin      (m_origin),
        .m_dir         (m_dir),
        .m_light       (m_light),
        .m_hit         (m_hit),
        .m_intensity   (m_intensity),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Job-level reference: a job accepted in cycle t0 starts at t0+1 and
    // delivers the marcher output seen in t0+M+1 as a response in t0+M+2.
    int            cyc, errors, checks;
    bit            have_job;
    int            t0, job_tag, last_grant;
    logic [VW-1:0] e_org, e_dir, e_lit;
    logic [N-1:0]  e_rsp_valid;
    logic          e_hit;
    logic [WD-1:0] e_int;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", name, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        have_job    = 1'b0;
        t0          = 0;
        job_tag     = 0;
        last_grant  = 0;
        e_org       = '0;
        e_dir       = '0;
        e_lit       = '0;
        e_rsp_valid = '0;
        e_hit       = 1'b0;
        e_int       = '0;
    endtask

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (last_grant + k) % int'(N);
            if (v[PW'(idx)]) return idx;
        end
        return -1;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < int'(N); i++) begin
            o_in[i] = VW'({$urandom, $urandom});
            d_in[i] = VW'({$urandom, $urandom});
            l_in[i] = VW'({$urandom, $urandom});
        end
        m_hit       = 1'($urandom);
        m_intensity = WD'($urandom);
    endtask

    // One clock cycle: drive, check at negedge, advance model, move past posedge.
    task automatic step(input logic [N-1:0] v, input logic ab);
        int           g;
        logic [N-1:0] exp_ready;
        req_valid = v;
        abort     = ab;
        @(negedge clk);
        g         = (!have_job && !ab) ? pick(v) : -1;
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        chk("busy",          64'(busy),          64'(have_job));
        chk("req_ready",     64'(req_ready),     64'(exp_ready));
        chk("m_start",       64'(m_start),       64'(have_job && !ab && cyc == t0 + 1));
        chk("m_origin",      64'(m_origin),      64'(e_org));
        chk("m_dir",         64'(m_dir),         64'(e_dir));
        chk("m_light",       64'(m_light),       64'(e_lit));
        chk("rsp_valid",     64'(rsp_valid),     64'(e_rsp_valid));
        chk("rsp_hit",       64'(rsp_hit),       64'(e_hit));
        chk("rsp_intensity", 64'(rsp_intensity), 64'(e_int));
        e_rsp_valid = '0;
        if (have_job) begin
            if (ab) begin
                have_job = 1'b0;
            end else if (cyc == t0 + int'(M) + 1) begin
                e_hit       = m_hit;
                e_int       = m_intensity;
                e_rsp_valid = N'(1) << job_tag;
                have_job    = 1'b0;
            end
        end else if (g >= 0) begin
            have_job   = 1'b1;
            t0         = cyc;
            job_tag    = g;
            last_grant = g;
            e_org      = o_in[PW'(g)];
            e_dir      = d_in[PW'(g)];
            e_lit      = l_in[PW'(g)];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rstep(input logic [N-1:0] v, input logic ab);
        rand_inputs();
        step(v, ab);
    endtask

    initial begin
        int c0;
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        abort  = 1'b0;
        req_valid = '0;
        rand_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state, then a single job from requester 0
        rstep(2'b00, 1'b0);
        rand_inputs();
        o_in[0][15:0] = 16'h0100;
        c0 = cyc;
        step(2'b01, 1'b0);
        chk("plan_origin_x", 64'(m_origin[15:0]), 64'h0100);
        while (cyc < c0 + 9) rstep(2'b00, 1'b0);
        rand_inputs();
        m_hit       = 1'b1;
        m_intensity = 16'h2A00;
        step(2'b00, 1'b0);
        rstep(2'b00, 1'b0);
        chk("plan_rsp_hit", 64'(rsp_hit), 64'h1);
        chk("plan_rsp_int", 64'(rsp_intensity), 64'h2A00);

        // Both requesters continuously valid, then requester 0 alone
        repeat (40) rstep(2'b11, 1'b0);
        repeat (30) rstep(2'b01, 1'b0);
        while (busy) rstep(2'b00, 1'b0);

        // Abort in cycle 5 of a job, pending request taken in cycle 6
        c0 = cyc;
        rstep(2'b01, 1'b0);
        while (cyc < c0 + 5) rstep(2'b10, 1'b0);
        rstep(2'b10, 1'b1);
        rstep(2'b10, 1'b0);
        while (busy) rstep(2'b00, 1'b0);

        // Abort coinciding with the final count
        c0 = cyc;
        rstep(2'b10, 1'b0);
        while (cyc < c0 + 9) rstep(2'b00, 1'b0);
        rstep(2'b00, 1'b1);
        repeat (3) rstep(2'b00, 1'b0);

        // Async reset in cycle 4 of a job
        c0 = cyc;
        rstep(2'b01, 1'b0);
        while (cyc < c0 + 4) rstep(2'b00, 1'b0);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy",      64'(busy),          64'h0);
        chk("rst_m_start",   64'(m_start),       64'h0);
        chk("rst_m_origin",  64'(m_origin),      64'h0);
        chk("rst_rsp_int",   64'(rsp_intensity), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid),     64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        repeat (12) rstep(2'b00, 1'b0);
        rstep(2'b11, 1'b0);
        chk("post_rst_tag1_origin", 64'(m_origin), 64'(o_in[1]));
        repeat (12) rstep(2'b00, 1'b0);

        // Randomised traffic with sparse aborts
        repeat (500) begin
            logic [N-1:0] v;
            v = N'($urandom);
            rstep(v, ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/march_scheduler.md
Name: march_scheduler

Overview:
- Time-shares one fixed-latency ray_cube marcher between NUM_REQ pixel requesters, for example two screen-half render cores.
- Arbitrates round-robin, latches the winner's operands, and pulses the marcher start.
- Counts the fixed march latency, then routes hit/intensity back to the winning requester with a one-cycle response strobe.
- Sits between the render cores and the single marcher instance.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
W, 16, signed component width
MARCH_CYCLES, 8, cycles from end of m_start cycle until marcher outputs are valid (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
abort  in  1  synchronous flush (frame restart)
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_origin  in  NUM_REQ*3*W  packed {z,y,x} per requester, requester 0 in LSBs
req_dir  in  NUM_REQ*3*W  packed {z,y,x}
req_light  in  NUM_REQ*3*W  packed {z,y,x}
rsp_valid  out  NUM_REQ  one-cycle result strobe to the owning requester
rsp_hit  out  1  registered surface hit
rsp_intensity  out  W  registered signed intensity
m_start  out  1  marcher start pulse
m_origin  out  3*W  held operands to marcher
m_dir  out  3*W  held operands to marcher
m_light  out  3*W  held operands to marcher
m_hit  in  1  marcher hit
m_intensity  in  W  marcher intensity
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state=IDLE, rr pointer=0, count=0.
  - All outputs 0, including m_* operand registers, rsp_hit and rsp_intensity.
- States: IDLE, ISSUE, BUSY.
- IDLE:
  - If abort=0 and any req_valid, the grant is the first set bit searching upward from (ptr+1) mod NUM_REQ, wrapping.
  - req_ready[grant]=1 combinationally in that cycle; a handshake is valid&ready.
  - On handshake: latch the granted requester's origin/dir/light into m_*, store tag=grant, set ptr=grant, go to ISSUE.
  - ptr changes only on grant.
- ISSUE:
  - m_start=1 for exactly this cycle; m_* stable.
  - count <= MARCH_CYCLES-1; go to BUSY.
- BUSY:
  - count decrements each cycle; m_* held stable.
  - In the cycle with count==0: sample m_hit/m_intensity into rsp_hit/rsp_intensity, assert rsp_valid[tag] for the next cycle only, go to IDLE.
- Latency and throughput:
  - Handshake in cycle T gives m_start in T+1 and rsp_valid in T+MARCH_CYCLES+2.
  - Maximum throughput is one job per MARCH_CYCLES+2 cycles (10 at default).
- req_ready is all-zero outside IDLE and whenever abort=1.
- rsp_hit/rsp_intensity hold their values until the next response; rsp_valid is never multi-hot.
- Abort:
  - In ISSUE or BUSY: the next state is IDLE, the job is discarded, no rsp_valid is produced, ptr keeps the last grant.
  - Abort coinciding with count==0: abort wins, no response and no result capture.
  - m_start is suppressed if abort=1 in ISSUE.
- Requester dropping req_valid after handshake: no effect.
- Requester that never raises valid: skipped with no cycle penalty.
- Async reset mid-job: immediate return to reset values; no stale response afterwards.

Decomposition:
- Shared package march_pkg holds:
  - W and VEC_W=3*W constants.
  - State enum encoding: IDLE=0, ISSUE=1, BUSY=2.
  - MARCH_CYCLES default, so the marcher and render cores share it.
- Sub-module rr_arbiter: combinational round-robin grant from (req, ptr), outputting a one-hot grant and a grant_valid. The scheduler owns ptr.

Test Plan:
- Single job, default params: req_valid[0]=1 with origin x=0x0100 in cycle 0.
  - req_ready[0]=1 in cycle 0 and m_start=1 in cycle 1, with m_origin x=0x0100.
  - Marcher drives m_hit=1, m_intensity=0x2A00 in cycle 9; rsp_valid=2'b01 in cycle 10 with rsp_hit=1, rsp_intensity=0x2A00.
- Simultaneous requests after reset (ptr=0), both valid continuously:
  - Grants alternate 1,0,1,0, handshakes 10 cycles apart.
  - rsp_valid alternates 2'b10,2'b01.
- Back-to-back, only requester 0 valid: handshakes at cycles 0,10,20; m_start at 1,11,21; busy low only in cycles 0,10,20.
- Abort asserted in cycle 5 of a job (BUSY): no rsp_valid, state IDLE in cycle 6, next pending request accepted in cycle 6.
- Abort coinciding with count==0 (cycle 9): no rsp_valid in cycle 10, rsp_hit/rsp_intensity unchanged from the prior response.
- rst_n pulsed low in cycle 4 of a job: all outputs 0 immediately, no rsp_valid after release; first post-reset grant with both valid goes to requester 1.
